spray_timer: RTL and testbench

- Timer that sits on the other end of the sprayer controller's timer interface.
- The controller pulses clrt to clear and arm it, and holds spray while spraying.
- The block counts prescaled ticks up to a programmable duration, then returns tdone, which the controller uses to leave its spray state.
- It also keeps a saturating count of completed spray cycles for status readout.

---
 rtl/spray_timer.sv | 104 ++++++++++
 tb/tb_spray_timer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spray_timer.sv
// spray_timer: prescaled spray-duration timer answering the sprayer controller.
//   clrt clears and arms the timer. spray runs it. tdone reports expiry. A saturating counter
//   records how many times the timer has entered DONE.
// Latency: tdone rises 1 + dur*PRESCALE edges after the first ARMED edge with spray=1.
//   tdone and busy are registered, so they change on the same edge as the state.
// Backpressure: none. Dropping spray pauses counting in RUN, and clrt overrides every state.
// Ports:
//   clk, reset        system clock and async active-high reset
//   clrt, spray, dur  controller requests and the duration sampled on clrt
//   tdone, busy       state decodes DONE and RUN
//   elapsed           ticks counted since the last clear
//   spray_count       number of DONE entries, saturating

module spray_timer #(
  parameter int PRESCALE = 4,
  parameter int DUR_W    = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clrt,
  input  logic             spray,
  input  logic [DUR_W-1:0] dur,
  output logic             tdone,
  output logic             busy,
  output logic [DUR_W-1:0] elapsed,
  output logic [CNT_W-1:0] spray_count
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [DUR_W-1:0] elapsed_nxt;
  logic [DUR_W-1:0] limit, limit_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             enter_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      presc       <= '0;
      elapsed     <= '0;
      limit       <= '0;
      spray_count <= '0;
      tdone       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      elapsed     <= elapsed_nxt;
      limit       <= limit_nxt;
      spray_count <= count_nxt;
      // Outputs are registered copies of the next-state decode, so they stay aligned with state.
      tdone       <= (state_nxt == DONE);
      busy        <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    elapsed_nxt = elapsed;
    limit_nxt   = limit;
    if (clrt) begin
      // Clear/arm wins over everything, including spray in the same cycle.
      state_nxt   = ARMED;
      limit_nxt   = dur;
      elapsed_nxt = '0;
      presc_nxt   = '0;
    end else begin
      case (state)
        ARMED: begin
          if (spray) state_nxt = (limit == '0) ? DONE : RUN;
        end
        RUN: begin
          if (spray) begin
            if (presc == PMAX) begin
              presc_nxt   = '0;
              elapsed_nxt = elapsed + DUR_W'(1);
              // elapsed stops at limit, so it can never wrap.
              if (elapsed + DUR_W'(1) == limit) state_nxt = DONE;
            end else begin
              presc_nxt = presc + PW'(1);
            end
          end
        end
        default: ;  // IDLE and DONE wait for clrt.
      endcase
    end
  end

  assign enter_done = (state_nxt == DONE) && (state != DONE);

  always_comb begin
    count_nxt = spray_count;
    if (enter_done && spray_count != CMAX) count_nxt = spray_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_spray_timer.sv
// tb_spray_timer: bench for spray_timer with PRESCALE=4 and CNT_W=2.
//   Each step drives one cycle of inputs and pushes the outputs expected after the next edge.
//   The step then pops that entry and compares it with the DUT. The async-reset checks are made directly.

module tb_spray_timer;

  localparam int P     = 4;
  localparam int DUR_W = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             clrt;
  logic             spray;
  logic [DUR_W-1:0] dur;
  logic             tdone;
  logic             busy;
  logic [DUR_W-1:0] elapsed;
  logic [CNT_W-1:0] spray_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic             tdone;
    logic             busy;
    logic [DUR_W-1:0] elapsed;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  spray_timer #(.PRESCALE(P), .DUR_W(DUR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .clrt        (clrt),
    .spray       (spray),
    .dur         (dur),
    .tdone       (tdone),
    .busy        (busy),
    .elapsed     (elapsed),
    .spray_count (spray_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle, queue the outputs expected after the edge, then compare them.
  task automatic step(input string tag, input logic c, input logic s, input int d,
                      input logic e_done, input logic e_busy, input int e_el, input int e_cnt);
    exp_t e;
    @(negedge clk);
    clrt  = c;
    spray = s;
    dur   = DUR_W'(d);
    e.tdone   = e_done;
    e.busy    = e_busy;
    e.elapsed = DUR_W'(e_el);
    e.cnt     = CNT_W'(e_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".tdone"},   int'(tdone),       int'(e.tdone));
      chk({tag, ".busy"},    int'(busy),        int'(e.busy));
      chk({tag, ".elapsed"}, int'(elapsed),     int'(e.elapsed));
      chk({tag, ".count"},   int'(spray_count), int'(e.cnt));
    end
  endtask

  initial begin
    reset = 1'b1;
    clrt  = 1'b0;
    spray = 1'b0;
    dur   = '0;
    #3;
    chk("rst.tdone",   int'(tdone),       0);
    chk("rst.busy",    int'(busy),        0);
    chk("rst.elapsed", int'(elapsed),     0);
    chk("rst.count",   int'(spray_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Nominal run: dur=3 expires 12 RUN edges after entering RUN.
    step("idle0", 0, 1, 0, 0, 0, 0, 0);  // spray is ignored in IDLE
    step("idle1", 0, 0, 0, 0, 0, 0, 0);
    step("nom.arm", 1, 0, 3, 0, 0, 0, 0);
    step("nom.run", 0, 1, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      if (k < 12) step("nom.cnt", 0, 1, 0, 0, 1, k / P, 0);
      else        step("nom.end", 0, 1, 0, 1, 0, 3, 1);
    end
    step("nom.hold", 0, 1, 0, 1, 0, 3, 1);
    step("nom.hold2", 0, 0, 0, 1, 0, 3, 1);

    // Pause for 5 cycles with the prescaler mid-tick. Expiry moves exactly 5 edges later.
    step("pau.arm", 1, 0, 3, 0, 0, 0, 1);
    step("pau.run", 0, 1, 0, 0, 1, 0, 1);
    for (int k = 1; k <= 6; k++) step("pau.pre", 0, 1, 0, 0, 1, k / P, 1);
    for (int k = 0; k < 5; k++)  step("pau.hold", 0, 0, 0, 0, 1, 1, 1);
    for (int k = 7; k <= 12; k++) begin
      if (k < 12) step("pau.post", 0, 1, 0, 0, 1, k / P, 1);
      else        step("pau.end", 0, 1, 0, 1, 0, 3, 2);
    end

    // Zero duration: ARMED goes straight to DONE.
    step("zero.arm", 1, 0, 0, 0, 0, 0, 2);
    step("zero.arm2", 0, 0, 0, 0, 0, 0, 2);  // stays ARMED without spray
    step("zero.done", 0, 1, 0, 1, 0, 0, 3);

    // Clear priority: clrt with spray at elapsed=2. Held clrt re-arms with dur=20, then 80 RUN edges.
    step("clr.arm0", 1, 0, 3, 0, 0, 0, 3);
    step("clr.run", 0, 1, 0, 0, 1, 0, 3);
    for (int k = 1; k <= 8; k++) step("clr.cnt", 0, 1, 0, 0, 1, k / P, 3);
    step("clr.clr", 1, 1, 5, 0, 0, 0, 3);
    step("clr.rearm", 1, 1, 20, 0, 0, 0, 3);
    step("clr.run2", 0, 1, 0, 0, 1, 0, 3);
    for (int k = 1; k <= 80; k++) begin
      if (k < 80) step("clr.cnt2", 0, 1, 0, 0, 1, k / P, 3);
      else        step("clr.end", 0, 1, 0, 1, 0, 20, 3);  // count already saturated at 3
    end

    // Async reset mid-run clears the outputs before the next edge.
    step("ar.arm", 1, 0, 3, 0, 0, 0, 3);
    step("ar.run", 0, 1, 0, 0, 1, 0, 3);
    for (int k = 1; k <= 5; k++) step("ar.cnt", 0, 1, 0, 0, 1, k / P, 3);
    reset = 1'b1;
    #1;
    chk("ar.tdone",   int'(tdone),       0);
    chk("ar.busy",    int'(busy),        0);
    chk("ar.elapsed", int'(elapsed),     0);
    chk("ar.count",   int'(spray_count), 0);
    #1;
    reset = 1'b0;
    step("ar.idle", 0, 1, 0, 0, 0, 0, 0);  // clrt is needed to restart
    step("ar.idle2", 0, 1, 0, 0, 0, 0, 0);

    // Saturation: five zero-duration cycles read 1,2,3,3,3.
    for (int i = 1; i <= 5; i++) begin
      step("sat.arm", 1, 0, 0, 0, 0, 0, (i - 1 > 3) ? 3 : i - 1);
      step("sat.done", 0, 1, 0, 1, 0, 0, (i > 3) ? 3 : i);
    end

    chk("sb.drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
